// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared types for the pipeline hazard unit.
//   hz_state_t  - hazard controller FSM state (RUN / STALL)
//   fwd_sel_t   - Execute operand source select (register file, WB, MEM)
//   HZ_CNT_W    - width of the remaining-stall down-counter; holds up to
//                 LOAD_LAT+1 = 5 for the largest supported load latency.
package rv32i_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } hz_state_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  localparam int HZ_CNT_W = 3;

endpackage

// File: rtl/hazard_fwd_sel.sv
// hazard_fwd_sel: combinational forwarding select for one Execute operand.
//   src               in  source register index of the operand in Execute
//   RdM, regwriteM    in  destination / write-enable of the Memory stage
//   RdW, regwriteW    in  destination / write-enable of the Writeback stage
//   sel               out FWD_MEM if M writes src, else FWD_WB if W writes
//                         src, else FWD_RF. Index 0 is never forwarded.
module hazard_fwd_sel
  import rv32i_pkg::*;
#(
  parameter int REG_WIDTH = 5
) (
  input  logic [REG_WIDTH-1:0] src,
  input  logic [REG_WIDTH-1:0] RdM,
  input  logic                 regwriteM,
  input  logic [REG_WIDTH-1:0] RdW,
  input  logic                 regwriteW,
  output fwd_sel_t             sel
);

  logic hit_m;
  logic hit_w;

  assign hit_m = regwriteM && (RdM != '0) && (RdM == src);
  assign hit_w = regwriteW && (RdW != '0) && (RdW == src);

  // The younger result (Memory) wins over the older one (Writeback).
  always_comb begin
    sel = FWD_RF;
    if (hit_m)      sel = FWD_MEM;
    else if (hit_w) sel = FWD_WB;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard detection, stall/flush control and operand
// forwarding select for a 5-stage RV32I pipeline.
//   Build option: define HAZARD_FORWARDING_EN to enable the forwarding
//   datapath; otherwise every RAW hazard is resolved by stalling.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   Rs1D, Rs2D                sources of the instruction in Decode
//   Rs1E, Rs2E                sources of the instruction in Execute
//   RdE/RdM/RdW, regwriteX    destinations and write enables per stage
//   memreadE                  Execute holds a load
//   branch_takenE             Execute redirects the PC
//   stallF, stallD            hold PC and IF/ID
//   flushD, flushE            bubble IF/ID and ID/EX
//   fwdAE, fwdBE              operand A/B source select
//   stall_cycles              saturating count of cycles with stallD=1
//   state                     debug view of the FSM state
// Handshake: none; all outputs are combinational from state and inputs and
// are forced to 0 while rst is high.
module hazard_ctrl
  import rv32i_pkg::*;
#(
  parameter int REG_WIDTH = 5,
  parameter int LOAD_LAT  = 1,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_WIDTH-1:0] Rs1D,
  input  logic [REG_WIDTH-1:0] Rs2D,
  input  logic [REG_WIDTH-1:0] Rs1E,
  input  logic [REG_WIDTH-1:0] Rs2E,
  input  logic [REG_WIDTH-1:0] RdE,
  input  logic [REG_WIDTH-1:0] RdM,
  input  logic [REG_WIDTH-1:0] RdW,
  input  logic                 regwriteE,
  input  logic                 regwriteM,
  input  logic                 regwriteW,
  input  logic                 memreadE,
  input  logic                 branch_takenE,
  output logic                 stallF,
  output logic                 stallD,
  output logic                 flushD,
  output logic                 flushE,
  output fwd_sel_t             fwdAE,
  output fwd_sel_t             fwdBE,
  output logic [CNT_WIDTH-1:0] stall_cycles,
  output hz_state_t            state
);

  hz_state_t             state_q, state_d;
  logic [HZ_CNT_W-1:0]   cnt_q, cnt_d;
  logic [HZ_CNT_W-1:0]   need_1, need_2, need;
  logic [CNT_WIDTH-1:0]  stall_cnt_q;
  logic                  stall, flush_d, flush_e;

  function automatic logic hits(input logic we,
                                input logic [REG_WIDTH-1:0] rd,
                                input logic [REG_WIDTH-1:0] src);
    return we && (rd != '0) && (rd == src);
  endfunction

  // Stall cycles demanded by one Decode source.
  function automatic logic [HZ_CNT_W-1:0] src_need(input logic [REG_WIDTH-1:0] s);
    logic [HZ_CNT_W-1:0] n;
    n = '0;
`ifdef HAZARD_FORWARDING_EN
    // Only a load's data arrives too late to forward.
    if (memreadE && hits(regwriteE, RdE, s)) n = HZ_CNT_W'(LOAD_LAT);
`else
    // E hit: wait for writeback (2 cycles) plus extra load latency.
    // W hit needs nothing: the register file writes before it reads.
    if (hits(regwriteE, RdE, s))
      n = memreadE ? HZ_CNT_W'(LOAD_LAT + 1) : HZ_CNT_W'(2);
    else if (hits(regwriteM, RdM, s))
      n = HZ_CNT_W'(1);
`endif
    return n;
  endfunction

  assign need_1 = src_need(Rs1D);
  assign need_2 = src_need(Rs2D);
  assign need   = (need_1 > need_2) ? need_1 : need_2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  // A taken branch overrides any stall: the stalled instruction is on the
  // wrong path anyway.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    if (branch_takenE) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
      state_d = RUN;
      cnt_d   = '0;
    end else begin
      case (state_q)
        RUN: begin
          if (need != '0) begin
            stall   = 1'b1;
            flush_e = 1'b1;
            cnt_d   = need - 1'b1;
            state_d = (need > HZ_CNT_W'(1)) ? STALL : RUN;
          end
        end
        STALL: begin
          stall   = 1'b1;
          flush_e = 1'b1;
          cnt_d   = cnt_q - 1'b1;
          if (cnt_q == HZ_CNT_W'(1)) state_d = RUN;
        end
        default: begin
          state_d = RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign stallF       = stall & ~rst;
  assign stallD       = stall & ~rst;
  assign flushD       = flush_d & ~rst;
  assign flushE       = flush_e & ~rst;
  assign stall_cycles = rst ? '0 : stall_cnt_q;
  assign state        = rst ? RUN : state_q;

`ifdef HAZARD_FORWARDING_EN
  fwd_sel_t sel_a, sel_b;

  hazard_fwd_sel #(.REG_WIDTH(REG_WIDTH)) u_fwd_a (
    .src(Rs1E), .RdM(RdM), .regwriteM(regwriteM),
    .RdW(RdW), .regwriteW(regwriteW), .sel(sel_a)
  );

  hazard_fwd_sel #(.REG_WIDTH(REG_WIDTH)) u_fwd_b (
    .src(Rs2E), .RdM(RdM), .regwriteM(regwriteM),
    .RdW(RdW), .regwriteW(regwriteW), .sel(sel_b)
  );

  assign fwdAE = rst ? FWD_RF : sel_a;
  assign fwdBE = rst ? FWD_RF : sel_b;
`else
  // Execute sources and the Writeback stage play no part without forwarding.
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{Rs1E, Rs2E, RdW, regwriteW};
  assign fwdAE = FWD_RF;
  assign fwdBE = FWD_RF;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed-vector bench for hazard_ctrl. Three instances
// share one input set: _a default parameters, _b LOAD_LAT=3, _c CNT_WIDTH=4.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       regwriteE, regwriteM, regwriteW, memreadE, branch_takenE;

  logic        stallF_a, stallD_a, flushD_a, flushE_a, state_a;
  logic [1:0]  fwdAE_a, fwdBE_a;
  logic [31:0] stall_cycles_a;
  logic        stallF_b, stallD_b, flushD_b, flushE_b, state_b;
  logic [1:0]  fwdAE_b, fwdBE_b;
  logic [31:0] stall_cycles_b;
  logic        stallF_c, stallD_c, flushD_c, flushE_c, state_c;
  logic [1:0]  fwdAE_c, fwdBE_c;
  logic [3:0]  stall_cycles_c;

  int n_vec = 0;
  int n_bad = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  hazard_ctrl dut_a (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .regwriteE(regwriteE), .regwriteM(regwriteM),
    .regwriteW(regwriteW), .memreadE(memreadE), .branch_takenE(branch_takenE),
    .stallF(stallF_a), .stallD(stallD_a), .flushD(flushD_a), .flushE(flushE_a),
    .fwdAE(fwdAE_a), .fwdBE(fwdBE_a), .stall_cycles(stall_cycles_a), .state(state_a)
  );

  hazard_ctrl #(.LOAD_LAT(3)) dut_b (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .regwriteE(regwriteE), .regwriteM(regwriteM),
    .regwriteW(regwriteW), .memreadE(memreadE), .branch_takenE(branch_takenE),
    .stallF(stallF_b), .stallD(stallD_b), .flushD(flushD_b), .flushE(flushE_b),
    .fwdAE(fwdAE_b), .fwdBE(fwdBE_b), .stall_cycles(stall_cycles_b), .state(state_b)
  );

  hazard_ctrl #(.CNT_WIDTH(4)) dut_c (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .regwriteE(regwriteE), .regwriteM(regwriteM),
    .regwriteW(regwriteW), .memreadE(memreadE), .branch_takenE(branch_takenE),
    .stallF(stallF_c), .stallD(stallD_c), .flushD(flushD_c), .flushE(flushE_c),
    .fwdAE(fwdAE_c), .fwdBE(fwdBE_c), .stall_cycles(stall_cycles_c), .state(state_c)
  );

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
    RdE = 5'd0; RdM = 5'd0; RdW = 5'd0;
    regwriteE = 1'b0; regwriteM = 1'b0; regwriteW = 1'b0;
    memreadE = 1'b0; branch_takenE = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    settle();
  endtask

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    step();
    settle();
    check("rst_stallD", 32'(stallD_a), 32'd0);
    check("rst_flushE", 32'(flushE_a), 32'd0);
    apply_reset();
    check("rst_state", 32'(state_a), 32'd0);
    check("rst_cycles", stall_cycles_a, 32'd0);

`ifdef HAZARD_FORWARDING_EN
    // Load-use hazard with LOAD_LAT=1: one stall cycle.
    regwriteE = 1'b1; memreadE = 1'b1; RdE = 5'd5; Rs1D = 5'd5;
    settle();
    check("ld_stallD", 32'(stallD_a), 32'd1);
    check("ld_stallF", 32'(stallF_a), 32'd1);
    check("ld_flushE", 32'(flushE_a), 32'd1);
    check("ld_flushD", 32'(flushD_a), 32'd0);
    step();
    clear_inputs();
    settle();
    check("ld_done_stallD", 32'(stallD_a), 32'd0);
    check("ld_done_state", 32'(state_a), 32'd0);
    check("ld_cycles", stall_cycles_a, 32'd1);

    // ALU result is forwarded: no stall.
    regwriteE = 1'b1; RdE = 5'd5; Rs2D = 5'd5;
    settle();
    check("alu_fwd_nostall", 32'(stallD_a), 32'd0);
    clear_inputs();

    // Forwarding priority M over W.
    regwriteM = 1'b1; RdM = 5'd3; regwriteW = 1'b1; RdW = 5'd3; Rs1E = 5'd3; Rs2E = 5'd3;
    settle();
    check("fwdA_mem", 32'(fwdAE_a), 32'd2);
    check("fwdB_mem", 32'(fwdBE_a), 32'd2);
    RdM = 5'd0;
    settle();
    check("fwdA_wb", 32'(fwdAE_a), 32'd1);
    Rs2E = 5'd9;
    settle();
    check("fwdB_none", 32'(fwdBE_a), 32'd0);
    regwriteW = 1'b0;
    settle();
    check("fwdA_rf", 32'(fwdAE_a), 32'd0);

    // LOAD_LAT=3 load stalls 3 cycles.
    apply_reset();
    regwriteE = 1'b1; memreadE = 1'b1; RdE = 5'd4; Rs2D = 5'd4;
    settle();
    for (int i = 0; i < 3; i++) begin
      check("lat3_stall", 32'(stallD_b), 32'd1);
      step();
      clear_inputs();
      settle();
    end
    check("lat3_end", 32'(stallD_b), 32'd0);
    check("lat3_cycles", stall_cycles_b, 32'd3);
`else
    // ALU producer in E: two stall cycles.
    regwriteE = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
    settle();
    check("alu_c1_stallD", 32'(stallD_a), 32'd1);
    check("alu_c1_stallF", 32'(stallF_a), 32'd1);
    check("alu_c1_flushE", 32'(flushE_a), 32'd1);
    check("alu_c1_flushD", 32'(flushD_a), 32'd0);
    check("fwd_off_A", 32'(fwdAE_a), 32'd0);
    step();
    clear_inputs();
    settle();
    check("alu_c2_stallD", 32'(stallD_a), 32'd1);
    check("alu_c2_state", 32'(state_a), 32'd1);
    step();
    settle();
    check("alu_end_stallD", 32'(stallD_a), 32'd0);
    check("alu_end_state", 32'(state_a), 32'd0);
    check("alu_cycles", stall_cycles_a, 32'd2);

    // Producer in M only: one stall cycle, FSM stays in RUN.
    apply_reset();
    regwriteM = 1'b1; RdM = 5'd7; Rs1D = 5'd7; Rs1E = 5'd7;
    settle();
    check("m_stallD", 32'(stallD_a), 32'd1);
    check("m_state", 32'(state_a), 32'd0);
    check("fwd_off_M", 32'(fwdAE_a), 32'd0);
    step();
    clear_inputs();
    settle();
    check("m_end_stallD", 32'(stallD_a), 32'd0);
    check("m_cycles", stall_cycles_a, 32'd1);

    // Register 0 never hits; W hit needs no stall.
    regwriteE = 1'b1; RdE = 5'd0; Rs1D = 5'd0;
    settle();
    check("x0_nostall", 32'(stallD_a), 32'd0);
    clear_inputs();
    regwriteW = 1'b1; RdW = 5'd6; Rs2D = 5'd6;
    settle();
    check("w_nostall", 32'(stallD_a), 32'd0);

    // LOAD_LAT=3 load: branch in stall cycle 2 overrides the stall.
    apply_reset();
    regwriteE = 1'b1; memreadE = 1'b1; RdE = 5'd4; Rs1D = 5'd4;
    settle();
    check("ld3_c1_stallD", 32'(stallD_b), 32'd1);
    step();
    clear_inputs();
    settle();
    check("ld3_c2_state", 32'(state_b), 32'd1);
    branch_takenE = 1'b1;
    settle();
    check("br_flushD", 32'(flushD_b), 32'd1);
    check("br_flushE", 32'(flushE_b), 32'd1);
    check("br_stallD", 32'(stallD_b), 32'd0);
    check("br_stallF", 32'(stallF_b), 32'd0);
    step();
    branch_takenE = 1'b0;
    settle();
    check("br_state", 32'(state_b), 32'd0);
    check("br_after_stallD", 32'(stallD_b), 32'd0);
    check("br_cycles", stall_cycles_b, 32'd1);

    // LOAD_LAT=3 load without branch: four stall cycles (dut_a: two).
    apply_reset();
    regwriteE = 1'b1; memreadE = 1'b1; RdE = 5'd4; Rs1D = 5'd4;
    settle();
    for (int i = 0; i < 4; i++) begin
      check("ld3_stall", 32'(stallD_b), 32'd1);
      step();
      clear_inputs();
      settle();
    end
    check("ld3_end", 32'(stallD_b), 32'd0);
    check("ld3_cycles", stall_cycles_b, 32'd4);
    check("ld1_cycles", stall_cycles_a, 32'd2);
`endif

    // Reset in the first stall cycle aborts the stall.
    apply_reset();
    regwriteE = 1'b1; memreadE = 1'b1; RdE = 5'd7; Rs1D = 5'd7;
    settle();
    check("rs_pre_stallD", 32'(stallD_a), 32'd1);
    rst = 1'b1;
    settle();
    check("rs_stallD", 32'(stallD_a), 32'd0);
    check("rs_stallF", 32'(stallF_a), 32'd0);
    check("rs_flushE", 32'(flushE_a), 32'd0);
    step();
    clear_inputs();
    settle();
    rst = 1'b0;
    settle();
    check("rs_state", 32'(state_a), 32'd0);
    check("rs_cycles", stall_cycles_a, 32'd0);
    check("rs_after_stallD", 32'(stallD_a), 32'd0);
    step();
    settle();
    check("rs_next_stallD", 32'(stallD_a), 32'd0);

    // Hazard held for 20 cycles: 4-bit counter saturates, 32-bit counts on.
    apply_reset();
    regwriteE = 1'b1; memreadE = 1'b1; RdE = 5'd7; Rs1D = 5'd7;
    settle();
    repeat (20) step();
    settle();
    check("sat_stallD", 32'(stallD_c), 32'd1);
    check("sat_cycles4", 32'(stall_cycles_c), 32'd15);
    check("nosat_cycles32", stall_cycles_a, 32'd20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
